// File: rtl/peripheral_bus_master_pkg.sv
// Shared types and request-address field layout for the peripheral bus master.
// Optional build macro PBM_TXN_CNT_EN is consumed by peripheral_bus_master.
package peripheral_bus_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_RESP   = 2'd3
  } pbm_state_e;

  localparam int REQ_AW  = 8;
  localparam int SEL_LSB = 4;
  localparam int SEL_W   = 4;

  function automatic logic [SEL_W-1:0] addr_sel(input logic [REQ_AW-1:0] a);
    return a[SEL_LSB +: SEL_W];
  endfunction

endpackage

// File: rtl/peripheral_cs_decoder.sv
// Peripheral select decoder: one-hot chip select plus an out-of-range flag.
module peripheral_cs_decoder
  import peripheral_bus_master_pkg::*;
#(
  parameter int NUM_PERIPH = 4
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [NUM_PERIPH-1:0] cs,
  output logic                  out_of_range
);

  always_comb begin
    out_of_range = (int'(sel) >= NUM_PERIPH);
    cs = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      if (en && !out_of_range && (int'(sel) == k)) cs[k] = 1'b1;
    end
  end

endmodule

// File: rtl/peripheral_bus_master.sv
// Host request/response to cs/rd/wr strobe bridge for memory-mapped peripherals.
// Define PBM_TXN_CNT_EN to add the txn_count output (completed-response counter).
module peripheral_bus_master
  import peripheral_bus_master_pkg::*;
#(
  parameter int NUM_PERIPH    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int DATA_W        = 16,
  parameter int REG_AW        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [REQ_AW-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [REG_AW-1:0]            addr,
  output logic [NUM_PERIPH-1:0]        cs,
  output logic                         rd,
  output logic                         wr,
  output logic [DATA_W-1:0]            wdata,
  input  logic [NUM_PERIPH*DATA_W-1:0] data_in
`ifdef PBM_TXN_CNT_EN
  ,
  output logic [15:0]                  txn_count
`endif
);

  localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

  pbm_state_e              state;
  logic                    we_q;
  logic [SEL_W-1:0]        sel_q;
  logic [CNT_W-1:0]        strb_cnt;
  logic                    accept;
  logic [NUM_PERIPH-1:0]   dec_cs;
  logic                    dec_oor;
  logic signed [DATA_W-1:0] rd_mux;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  peripheral_cs_decoder #(
    .NUM_PERIPH(NUM_PERIPH)
  ) u_cs_decoder (
    .sel         (addr_sel(req_addr)),
    .en          (accept),
    .cs          (dec_cs),
    .out_of_range(dec_oor)
  );

  // Read-data mux from the latched select; only consulted for in-range reads.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      if (int'(sel_q) == k) rd_mux = data_in[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      sel_q     <= '0;
      strb_cnt  <= '0;
      cs        <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef PBM_TXN_CNT_EN
      txn_count <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q  <= req_we;
            sel_q <= addr_sel(req_addr);
            if (dec_oor) begin
              // Out-of-range select: answer immediately, peripherals never see it.
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state   <= ST_SETUP;
              cs      <= dec_cs;
              addr    <= req_addr[REG_AW-1:0];
              wdata   <= req_wdata;
              rsp_err <= 1'b0;
            end
          end
        end
        ST_SETUP: begin
          state    <= ST_STROBE;
          rd       <= ~we_q;
          wr       <= we_q;
          strb_cnt <= '0;
        end
        ST_STROBE: begin
          if (strb_cnt == CNT_LAST) begin
            state     <= ST_RESP;
            cs        <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? '0 : rd_mux;
          end else begin
            strb_cnt <= strb_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
`ifdef PBM_TXN_CNT_EN
            txn_count <= txn_count + 16'd1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Directed plus randomized bench for peripheral_bus_master with a transaction-level reference model.
module tb_peripheral_bus_master;

  localparam int NP = 4;
  localparam int SC = 2;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [7:0]    req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] addr;
  logic [NP-1:0] cs;
  logic          rd;
  logic          wr;
  logic [DW-1:0] wdata;
  logic [NP*DW-1:0] data_in;
  logic [DW-1:0] slot [NP];
`ifdef PBM_TXN_CNT_EN
  logic [15:0]   txn_count;
  int            exp_count = 0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < NP; k++) data_in[k*DW +: DW] = slot[k];
  end

  peripheral_bus_master #(
    .NUM_PERIPH(NP), .STROBE_CYCLES(SC), .DATA_W(DW), .REG_AW(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .cs(cs), .rd(rd), .wr(wr), .wdata(wdata),
    .data_in(data_in)
`ifdef PBM_TXN_CNT_EN
    , .txn_count(txn_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request/response exchange, checked against the transaction-level rules.
  task automatic run_txn(input logic we, input logic [7:0] a, input logic [DW-1:0] wd, input int hold);
    int sel, exp_lat, lat, rd_n, wr_n;
    logic exp_err;
    logic [DW-1:0] exp_rd;
    logic [NP-1:0] exp_cs, cs_seen;
    sel     = int'(a[7:4]);
    exp_err = (sel >= NP);
    exp_lat = exp_err ? 1 : 2 + SC;
    exp_cs  = exp_err ? '0 : NP'(1 << sel);
    exp_rd  = (we || exp_err) ? '0 : slot[sel];
    lat = 0; rd_n = 0; wr_n = 0; cs_seen = '0;

    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_wdata = DW'($urandom);
    req_we    = 1'($urandom);

    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      cs_seen |= cs;
      if (rd) rd_n++;
      if (wr) wr_n++;
      chk("cs_onehot", 32'($countones(cs) <= 1), 32'd1);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (k == 1) begin
        chk("setup_strobe", {30'd0, rd, wr}, 32'd0);
        chk("setup_cs", 32'(cs), 32'(exp_cs));
      end
      if (cs != '0) begin
        chk("addr", 32'(addr), 32'(a[3:0]));
        if (we) chk("wdata", 32'(wdata), 32'(wd));
      end
      tick();
    end
    chk("latency", lat, exp_lat);
    chk("rd_cycles", rd_n, (!we && !exp_err) ? SC : 0);
    chk("wr_cycles", wr_n, (we && !exp_err) ? SC : 0);
    chk("cs_seen", 32'(cs_seen), 32'(exp_cs));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    chk("resp_quiet", {28'd0, cs, 2'd0} | {30'd0, rd, wr}, 32'd0);

    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", 32'(rsp_rdata), 32'(exp_rd));
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_quiet", 32'({cs, rd, wr}), 32'd0);
    end

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
`ifdef PBM_TXN_CNT_EN
    exp_count++;
    chk("txn_count", 32'(txn_count), 32'(exp_count & 16'hFFFF));
`endif
  endtask

  initial begin
    int waited;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int k = 0; k < NP; k++) slot[k] = DW'($urandom);

    // Reset held for 5 cycles
    repeat (5) tick();
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_rdwr", {30'd0, rd, wr}, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_addr_wdata", {12'd0, addr, wdata}, 32'd0);
`ifdef PBM_TXN_CNT_EN
    chk("rst_txn_count", 32'(txn_count), 32'd0);
`endif
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_after_rst", 32'({rsp_valid, cs, rd, wr}), 32'd0);
    chk("idle_ready_after_rst", 32'(req_ready), 32'd1);

    // Directed: write, read from slot 2, out-of-range select, backpressure
    run_txn(1'b1, 8'h01, 16'h1234, 0);
    slot[2] = 16'hBEEF;
    run_txn(1'b0, 8'h20, 16'h0000, 0);
    run_txn(1'b0, 8'h50, 16'h5555, 0);
    run_txn(1'b1, 8'hF7, 16'hAAAA, 2);
    slot[1] = DW'($urandom);
    run_txn(1'b0, 8'h1C, 16'h0000, 10);

    // Abort: reset asserted while the read strobe is active
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h33; req_wdata = '0;
    tick();
    req_valid = 1'b0;
    waited = 0;
    while (!rd && waited < 10) begin
      tick();
      waited++;
    end
    chk("abort_saw_rd", 32'(rd), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rdwr", {30'd0, rd, wr}, 32'd0);
    chk("abort_cs", 32'(cs), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
`ifdef PBM_TXN_CNT_EN
    exp_count = 0;
`endif
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_txn(1'b0, 8'h31, 16'h0000, 1);

    // Randomized traffic, including out-of-range selects
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NP; k++) slot[k] = DW'($urandom);
      run_txn(1'($urandom), 8'($urandom_range(0, 8'h7F)), DW'($urandom), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
